// File: rtl/tgl_pulse_conditioner_if.sv
// Bus bundle for the toggle pulse conditioner: control inputs and pulse/status outputs.
interface tgl_pulse_conditioner_if;
    logic       ena;
    logic       btn_in;
    logic       rep_en;
    logic       t_pulse;
    logic       held;
    logic [7:0] pulse_cnt;

    modport slave (
        input  ena, btn_in, rep_en,
        output t_pulse, held, pulse_cnt
    );

    modport master (
        output ena, btn_in, rep_en,
        input  t_pulse, held, pulse_cnt
    );
endinterface

// File: rtl/tgl_pulse_conditioner.sv
// Button conditioner: 2-flop synchronizer, debounce, press/auto-repeat FSM
// producing single-cycle toggle pulses and a wrapping pulse counter.
module tgl_pulse_conditioner #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned REP_DELAY  = 64,
    parameter int unsigned REP_PERIOD = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    tgl_pulse_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_t;

    localparam logic [7:0] DEB_LAST   = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] DELAY_LAST = 8'(REP_DELAY - 1);
    localparam logic [7:0] PER_LAST   = 8'(REP_PERIOD - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [7:0] deb_cnt_q, deb_cnt_d;
    logic       held_q, held_d;
    state_t     state_q, state_d;
    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       t_pulse_q, t_pulse_d;
    logic [7:0] pulse_cnt_q, pulse_cnt_d;

    always_comb begin
        sync1_d     = sync1_q;
        sync2_d     = sync2_q;
        deb_cnt_d   = deb_cnt_q;
        held_d      = held_q;
        state_d     = state_q;
        rep_cnt_d   = rep_cnt_q;
        t_pulse_d   = 1'b0;
        pulse_cnt_d = pulse_cnt_q;

        if (bus.ena) begin
            sync1_d = bus.btn_in;
            sync2_d = sync1_q;

            if (sync2_q != held_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    held_d    = sync2_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end else begin
                deb_cnt_d = '0;
            end

            // FSM reacts to the registered held level, so a release always wins
            // over a repeat that falls due in the same cycle.
            unique case (state_q)
                IDLE: begin
                    if (held_q) begin
                        state_d   = PRESSED;
                        rep_cnt_d = '0;
                        t_pulse_d = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!held_q) begin
                        state_d   = IDLE;
                        rep_cnt_d = '0;
                    end else if (!bus.rep_en) begin
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == DELAY_LAST) begin
                        state_d   = REPEAT;
                        rep_cnt_d = '0;
                        t_pulse_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 8'd1;
                    end
                end
                REPEAT: begin
                    if (!held_q) begin
                        state_d   = IDLE;
                        rep_cnt_d = '0;
                    end else if (!bus.rep_en) begin
                        state_d   = PRESSED;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == PER_LAST) begin
                        rep_cnt_d = '0;
                        t_pulse_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end
            endcase

            if (t_pulse_d) begin
                pulse_cnt_d = pulse_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_cnt_q   <= '0;
            held_q      <= 1'b0;
            state_q     <= IDLE;
            rep_cnt_q   <= '0;
            t_pulse_q   <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_cnt_q   <= deb_cnt_d;
            held_q      <= held_d;
            state_q     <= state_d;
            rep_cnt_q   <= rep_cnt_d;
            t_pulse_q   <= t_pulse_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign bus.t_pulse   = t_pulse_q;
    assign bus.held      = held_q;
    assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: doc/tgl_pulse_conditioner.md
TGL_PULSE_CONDITIONER -- requirements
Module: tgl_pulse_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive synchronized cycles of a new level required before that level is accepted as stable; legal range 2..255.
REQ-002 Parameter REP_DELAY, default 64: cycles from the press pulse to the first auto-repeat pulse; legal range 2..255.
REQ-003 Parameter REP_PERIOD, default 16: cycles between successive auto-repeat pulses; legal range 2..255.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  cycle enable; low freezes all state.
REQ-007 btn_in  input  1  raw asynchronous button level, active-high, bouncy.
REQ-008 rep_en  input  1  auto-repeat enable while the button is held.
REQ-009 t_pulse  output  1  single-cycle toggle request to the downstream T flip-flop input.
REQ-010 held  output  1  debounced stable button level.
REQ-011 pulse_cnt  output  8  count of t_pulse assertions, modulo 256.

Function
REQ-012 btn_in SHALL pass through a 2-stage flip-flop synchronizer before any other use; no other logic SHALL sample btn_in.
REQ-013 Debounce: each enabled cycle where synchronized level != held, the debounce counter increments; on the DEB_CYCLES-th consecutive differing cycle held takes the synchronized level and the counter clears.
REQ-014 Any enabled cycle where synchronized level == held SHALL clear the debounce counter, so a glitch shorter than DEB_CYCLES cycles never changes held.
REQ-015 FSM states: IDLE (held=0), PRESSED (held=1, awaiting repeat), REPEAT (held=1, repeating).
REQ-016 IDLE -> PRESSED when held rises; t_pulse SHALL be 1 for exactly the one cycle following the rise of held.
REQ-017 Latency: btn_in steady high before edge 1 -> held high after edge DEB_CYCLES+2 -> t_pulse high after edge DEB_CYCLES+3, for one cycle.
REQ-018 The repeat counter SHALL clear on entry to PRESSED and REPEAT and SHALL increment each enabled cycle.
REQ-019 PRESSED with rep_en=1: a repeat pulse SHALL occur exactly REP_DELAY cycles after the press pulse, with transition to REPEAT.
REQ-020 PRESSED with rep_en=0: repeat counter held at 0; REP_DELAY counting restarts from the cycle rep_en rises.
REQ-021 REPEAT with rep_en=1: t_pulse SHALL assert every REP_PERIOD cycles.
REQ-022 REPEAT with rep_en=0: return to PRESSED with the repeat counter cleared, and no pulse in that cycle.
REQ-023 held falling from PRESSED or REPEAT SHALL force IDLE; a release never generates t_pulse, and a repeat due in the same cycle is suppressed.
REQ-024 t_pulse SHALL never be high in two consecutive cycles.
REQ-025 pulse_cnt SHALL increment by 1 in the cycle t_pulse is high and wrap 255 -> 0.
REQ-026 ena=0: synchronizer, debounce counter, held, FSM, repeat counter and pulse_cnt hold their values; t_pulse is 0; a pending pulse is dropped, not deferred.
REQ-027 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-028 rst_n low SHALL asynchronously set synchronizer stages, debounce counter, held, repeat counter, t_pulse and pulse_cnt to 0 and the FSM to IDLE.
REQ-029 Reset asserted mid-press or mid-repeat SHALL abort with no pulse; after release, a still-high btn_in SHALL be treated as a new press requiring full debounce (REQ-017).
REQ-030 Release of rst_n needs no synchronous re-arm; operation starts on the first rising edge with rst_n high.

Verification (bench parameters DEB_CYCLES=4, REP_DELAY=8, REP_PERIOD=3, ena=1 unless stated)
REQ-031 Clean press: btn_in 0->1 before edge 1, rep_en=0 -> held=1 after edge 6, t_pulse=1 only after edge 7, pulse_cnt=1, no further pulses while held.
REQ-032 Bounce: btn_in high 3 cycles, low 1, high 3, low -> held stays 0, t_pulse never asserts, pulse_cnt=0.
REQ-033 Auto-repeat: rep_en=1, hold button 25 cycles past the press pulse at cycle P -> pulses at P, P+8, P+11, P+14, P+17, P+20, P+23; release -> no pulse; pulse_cnt=7.
REQ-034 Freeze: ena=0 for 5 cycles spanning the cycle a pulse is due -> no pulse in the window, counters unchanged; after ena=1 timing resumes from frozen counts.
REQ-035 Reset mid-repeat: rst_n low during REPEAT -> all outputs 0 immediately; btn_in still high -> next t_pulse 7 edges after rst_n release.
REQ-036 Wrap: 256 press/release cycles -> pulse_cnt returns to 0, t_pulse count equals 256.
